uart_cmd_assembler: RTL
=======================

// Module: uart_cmd_assembler
// PURPOSE
//  Downstream of the UART receiver. Consumes its byte stream (rx_rdy/rx_data, acked via clr_rdy).
//  Packs NUM_BYTES consecutive bytes, MSB first, into one command word for the command dispatcher.
//  Discards partial commands after an inter-byte timeout. Flags bytes dropped while a command is unconsumed.
// PARAMETERS
//  NUM_BYTES       3       bytes per command (opcode + 16-bit payload); legal range 2..4
//  TIMEOUT_CYCLES  20000   max clk cycles between bytes of one command before the partial is discarded
// PORTS
//  clk          in   1            system clock, all logic on posedge
//  rst          in   1            asynchronous, active-high reset
//  rx_rdy       in   1            byte-valid level from UART receiver, held until cleared
//  rx_data      in   8            received byte, stable while rx_rdy high
//  clr_rdy      out  1            1-cycle ack to UART receiver for each accepted or dropped byte
//  cmd          out  8*NUM_BYTES  assembled command; byte 0 lands in the top byte
//  cmd_rdy      out  1            command valid, held until clr_cmd_rdy
//  clr_cmd_rdy  in   1            consumer ack; clears cmd_rdy next cycle
//  overrun      out  1            1-cycle pulse: byte arrived in DONE without clr_cmd_rdy, byte dropped
//  timeout_err  out  1            1-cycle pulse: partial command discarded on timeout
//  chk_err      out  1            1-cycle pulse on checksum mismatch (constant 0 without macro)
// BEHAVIOUR
//  Reset values: all outputs 0, cmd = 0, byte index = 0, timer = 0, state IDLE, rx_rdy_q = 0.
//  Byte event: byte_ev = rx_rdy & ~rx_rdy_q, with rx_rdy_q registered. One event per byte,
//   even if rx_rdy stays high for cycles after clr_rdy.
//  Every byte_ev, accepted or dropped, gives clr_rdy = 1 on the following cycle, for exactly 1 cycle.
//  FSM:
//   IDLE:    on byte_ev: shift byte into cmd shift register, idx = 1, timer cleared; go COLLECT.
//   COLLECT: on byte_ev: shift byte in, idx++, timer cleared.
//            When idx reaches NUM_BYTES: go DONE; cmd_rdy = 1 on the next cycle.
//            So cmd_rdy rises 1 cycle after byte_ev of the final byte.
//            Otherwise timer++ each cycle. When timer == TIMEOUT_CYCLES-1 with no byte_ev:
//            timeout_err pulse, idx = 0, go IDLE. cmd keeps its old value; cmd_rdy stays 0.
//            byte_ev on the same cycle as timer expiry: the byte is accepted and no timeout is raised.
//   DONE:    cmd and cmd_rdy held.
//            clr_cmd_rdy without byte_ev: cmd_rdy = 0, go IDLE.
//            clr_cmd_rdy with byte_ev on the same cycle: cmd_rdy = 0, byte taken as byte 0, go COLLECT.
//            byte_ev without clr_cmd_rdy: byte dropped, overrun pulse, cmd unchanged.
//  cmd updates only at command completion; intermediate bytes go to an internal shift register.
//  clr_cmd_rdy outside DONE is ignored.
//  rst asserted mid-command: everything returns to reset values immediately and the partial is lost.
//  Timer width: $clog2(TIMEOUT_CYCLES+1). Saturates, never wraps.
// CONFIGURATION
//  Macro UART_CMD_CHKSUM_EN:
//   defined:   the command is followed by one extra checksum byte. Collection runs to
//              idx == NUM_BYTES+1, and the timeout applies to the checksum byte too.
//              Accept if (sum of NUM_BYTES payload bytes + checksum) mod 256 == 8'hFF:
//              load cmd, assert cmd_rdy.
//              Otherwise: chk_err pulse 1 cycle after the checksum byte_ev, go IDLE,
//              cmd and cmd_rdy unchanged. The checksum byte is never placed in cmd.
//   undefined: no checksum byte and no sum logic; chk_err tied to 0.
// STRUCTURE
//  Package uart_cmd_pkg:
//   typedef enum logic [1:0] {IDLE, COLLECT, DONE} cmd_state_t
//   localparam CMD_CHK_TARGET = 8'hFF
//   default NUM_BYTES and TIMEOUT_CYCLES constants, shared with the dispatcher.
//  Sub-module uart_cmd_timeout: clear/enable/expire counter parameterised by TIMEOUT_CYCLES.
//  Shift register, byte index, edge detect and FSM stay in the top module.
// TESTING
//  1. Bytes 8'hA5, 8'h12, 8'h34 spaced 500 cycles:
//     three clr_rdy pulses; cmd = 24'hA51234; cmd_rdy high 1 cycle after 3rd byte_ev and held until clr_cmd_rdy.
//  2. rx_rdy held high 5 cycles for one byte: exactly one byte_ev and one clr_rdy.
//  3. Bytes 8'h01, 8'h02, then silence for TIMEOUT_CYCLES:
//     timeout_err pulses once; next 3 bytes 8'h0A, 8'h0B, 8'h0C give cmd = 24'h0A0B0C.
//  4. Command complete and clr_cmd_rdy withheld, then byte 8'h77:
//     overrun pulse, clr_rdy pulse, cmd unchanged.
//     Then 8'h55 together with clr_cmd_rdy: accepted as byte 0.
//  5. rst asserted after 2 of 3 bytes, then released:
//     all outputs 0; a fresh 3-byte sequence assembles correctly.
//  6. With UART_CMD_CHKSUM_EN: payload 8'h10, 8'h20, 8'h30:
//     checksum 8'h9F gives cmd_rdy with cmd = 24'h102030; checksum 8'h9E gives chk_err and no cmd_rdy.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_cmd_pkg -- shared types and defaults for the UART command path.
// Rev 1.0
// ----------------------------------------------------------------------------
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } cmd_state_t;

  localparam logic [7:0] CMD_CHK_TARGET     = 8'hFF;
  localparam int         CMD_NUM_BYTES      = 3;
  localparam int         CMD_TIMEOUT_CYCLES = 20000;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_timeout.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_cmd_timeout -- saturating inter-byte counter; expired at TIMEOUT_CYCLES-1.
// Rev 1.0
// ----------------------------------------------------------------------------
module uart_cmd_timeout
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = CMD_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int             CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_assembler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// uart_cmd_assembler -- packs NUM_BYTES UART bytes MSB-first into one command.
// Define UART_CMD_CHKSUM_EN to require a trailing checksum byte. Rev 1.0
// ----------------------------------------------------------------------------
module uart_cmd_assembler
  import uart_cmd_pkg::*;
#(
  parameter int NUM_BYTES      = CMD_NUM_BYTES,
  parameter int TIMEOUT_CYCLES = CMD_TIMEOUT_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  output logic                   clr_rdy,
  output logic [8*NUM_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  output logic                   overrun,
  output logic                   timeout_err,
  output logic                   chk_err
);

`ifdef UART_CMD_CHKSUM_EN
  localparam int TOTAL = NUM_BYTES + 1;
  localparam int SR_W  = 8 * NUM_BYTES;
`else
  // The last payload byte goes straight from rx_data into cmd.
  localparam int TOTAL = NUM_BYTES;
  localparam int SR_W  = 8 * (NUM_BYTES - 1);
`endif
  localparam logic [2:0] LAST_IDX = 3'(TOTAL - 1);

  cmd_state_t      state, state_n;
  logic            rx_rdy_q;
  logic            byte_ev;
  logic [2:0]      idx;
  logic [SR_W-1:0] sr;
  logic            shift_en, first_byte, last_byte, load_cmd, set_rdy, drop_rdy;
  logic            ovr_ev, tmo_ev, tmr_clr, tmr_en, tmr_exp, sum_ok;

  assign byte_ev = rx_rdy & ~rx_rdy_q;

`ifdef UART_CMD_CHKSUM_EN
  logic [7:0] sum;
  logic       chk_ev;
  assign sum_ok = (8'(sum + rx_data) == CMD_CHK_TARGET);
`else
  assign sum_ok  = 1'b1;
  assign chk_err = 1'b0;
`endif

  uart_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (tmr_clr),
    .enable (tmr_en),
    .expired(tmr_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    shift_en   = 1'b0;
    first_byte = 1'b0;
    last_byte  = 1'b0;
    load_cmd   = 1'b0;
    set_rdy    = 1'b0;
    drop_rdy   = 1'b0;
    ovr_ev     = 1'b0;
    tmo_ev     = 1'b0;
    tmr_clr    = 1'b1;
    tmr_en     = 1'b0;
`ifdef UART_CMD_CHKSUM_EN
    chk_ev     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (byte_ev) begin
          shift_en   = 1'b1;
          first_byte = 1'b1;
          state_n    = COLLECT;
        end
      end
      COLLECT: begin
        if (byte_ev) begin
          shift_en = 1'b1;
          if (idx == LAST_IDX) begin
            last_byte = 1'b1;
            if (sum_ok) begin
              load_cmd = 1'b1;
              set_rdy  = 1'b1;
              state_n  = DONE;
            end
`ifdef UART_CMD_CHKSUM_EN
            else begin
              chk_ev  = 1'b1;
              state_n = IDLE;
            end
`endif
          end
        end else begin
          tmr_clr = 1'b0;
          tmr_en  = 1'b1;
          if (tmr_exp) begin
            tmo_ev  = 1'b1;
            state_n = IDLE;
          end
        end
      end
      DONE: begin
        if (clr_cmd_rdy) begin
          drop_rdy = 1'b1;
          if (byte_ev) begin
            shift_en   = 1'b1;
            first_byte = 1'b1;
            state_n    = COLLECT;
          end else begin
            state_n = IDLE;
          end
        end else if (byte_ev) begin
          ovr_ev = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_rdy_q    <= 1'b0;
      idx         <= '0;
      sr          <= '0;
      cmd         <= '0;
      cmd_rdy     <= 1'b0;
      clr_rdy     <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      rx_rdy_q    <= rx_rdy;
      clr_rdy     <= byte_ev;
      overrun     <= ovr_ev;
      timeout_err <= tmo_ev;
      if (tmo_ev || last_byte) idx <= '0;
      else if (shift_en)       idx <= first_byte ? 3'd1 : idx + 3'd1;
      if (shift_en) sr <= {sr[SR_W-9:0], rx_data};
`ifdef UART_CMD_CHKSUM_EN
      if (load_cmd) cmd <= sr;
`else
      if (load_cmd) cmd <= {sr, rx_data};
`endif
      if (set_rdy)       cmd_rdy <= 1'b1;
      else if (drop_rdy) cmd_rdy <= 1'b0;
    end
  end

`ifdef UART_CMD_CHKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum     <= '0;
      chk_err <= 1'b0;
    end else begin
      chk_err <= chk_ev;
      if (shift_en) sum <= first_byte ? rx_data : 8'(sum + rx_data);
    end
  end
`endif

endmodule
`default_nettype wire
